// File: rtl/warp_pkg.sv
// Shared constants for the warp controller: CSR register indices, CTL/STAT
// bit positions and the frame sequencer state encoding.
package warp_pkg;

  localparam logic [2:0] REG_CTL       = 3'd0;
  localparam logic [2:0] REG_STAT      = 3'd1;
  localparam logic [2:0] REG_MESHADDR  = 3'd2;
  localparam logic [2:0] REG_MESHCOUNT = 3'd3;
  localparam logic [2:0] REG_MESHSIZE  = 3'd4;
  localparam logic [2:0] REG_FRAMECNT  = 3'd5;

  localparam int CTL_GO     = 0;
  localparam int CTL_CONT   = 1;
  localparam int CTL_IRQ_EN = 2;
  localparam int CTL_STOP   = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_IRQ   = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_MESH = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/warp_ctl.sv
// Frame sequencer for the texture-mapping unit: CSR block, shadowed mesh
// parameters, start/finish handshake with the mesh fetcher and pipeline drain.
module warp_ctl
  import warp_pkg::*;
#(
  parameter logic [3:0] CSR_ADDR = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic [29:0] meshaddr,
  output logic [6:0]  mesh_count_x,
  output logic [6:0]  mesh_count_y,
  output logic [10:0] mesh_size_x,
  output logic [10:0] mesh_size_y,
  output logic        start,
  input  logic        finished,
  input  logic        pipe_busy,
  output logic [2:0]  dbg_state
);

  // Handshake with the fetcher: start is a single-cycle pulse on the first
  // WAIT_ACK cycle; the fetcher drops finished the cycle after and raises it
  // again when its mesh walk is complete.

  logic [2:0]  state_q, state_d;
  logic        cont_q, cont_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_pend_q, irq_pend_d;
  logic [29:0] maddr_q, maddr_d;
  logic [6:0]  cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [10:0] size_x_q, size_x_d, size_y_q, size_y_d;
  logic [29:0] sh_addr_q, sh_addr_d;
  logic [6:0]  sh_cnt_x_q, sh_cnt_x_d, sh_cnt_y_q, sh_cnt_y_d;
  logic [10:0] sh_size_x_q, sh_size_x_d, sh_size_y_q, sh_size_y_d;
  logic [31:0] frame_q, frame_d;
  logic        start_q, start_d;
  logic        zero_q, zero_d;
  logic [31:0] csr_do_q, csr_do_d;

  logic        blk_sel;
  logic [2:0]  idx;
  logic        wr_ctl, wr_stat, wr_addr, wr_count, wr_size, go_wr;
  logic        unused_ok;

  assign blk_sel  = (csr_a[13:10] == CSR_ADDR);
  assign idx      = csr_a[2:0];
  assign wr_ctl   = blk_sel && csr_we && (idx == REG_CTL);
  assign wr_stat  = blk_sel && csr_we && (idx == REG_STAT);
  assign wr_addr  = blk_sel && csr_we && (idx == REG_MESHADDR);
  assign wr_count = blk_sel && csr_we && (idx == REG_MESHCOUNT);
  assign wr_size  = blk_sel && csr_we && (idx == REG_MESHSIZE);
  assign go_wr    = wr_ctl && csr_di[CTL_GO];
  assign unused_ok = ^{csr_a[9:3], csr_di[31:30]};

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    irq_en_d    = irq_en_q;
    irq_pend_d  = irq_pend_q;
    maddr_d     = maddr_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    size_x_d    = size_x_q;
    size_y_d    = size_y_q;
    sh_addr_d   = sh_addr_q;
    sh_cnt_x_d  = sh_cnt_x_q;
    sh_cnt_y_d  = sh_cnt_y_q;
    sh_size_x_d = sh_size_x_q;
    sh_size_y_d = sh_size_y_q;
    frame_d     = frame_q;
    zero_d      = zero_q;
    start_d     = (state_q == ST_LAUNCH);

    // Stop overrides a continuous bit in the same write, so go+stop is one frame.
    if (wr_ctl) begin
      cont_d   = csr_di[CTL_CONT] && !csr_di[CTL_STOP];
      irq_en_d = csr_di[CTL_IRQ_EN];
    end
    if (wr_addr) maddr_d = csr_di[29:0];
    if (wr_count) begin
      cnt_x_d = csr_di[6:0];
      cnt_y_d = csr_di[22:16];
    end
    if (wr_size) begin
      size_x_d = csr_di[10:0];
      size_y_d = csr_di[26:16];
    end
    if (wr_stat && csr_di[STAT_IRQ]) irq_pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go_wr) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        sh_addr_d   = maddr_q;
        sh_cnt_x_d  = cnt_x_q;
        sh_cnt_y_d  = cnt_y_q;
        sh_size_x_d = size_x_q;
        sh_size_y_d = size_y_q;
        state_d     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!finished) state_d = ST_WAIT_MESH;
      end
      ST_WAIT_MESH: begin
        zero_d = 1'b0;
        if (finished) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // zero_q remembers that pipe_busy was low on the previous DRAIN cycle.
        if (pipe_busy) begin
          zero_d = 1'b0;
        end else if (zero_q) begin
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          zero_d = 1'b1;
        end
      end
      ST_DONE: begin
        frame_d    = frame_q + 32'd1;
        irq_pend_d = 1'b1;
        state_d    = cont_d ? ST_LAUNCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_do_d = 32'd0;
    if (blk_sel) begin
      case (idx)
        REG_CTL:       csr_do_d = {28'd0, 1'b0, irq_en_q, cont_q, 1'b0};
        REG_STAT:      csr_do_d = {30'd0, irq_pend_q, (state_q != ST_IDLE)};
        REG_MESHADDR:  csr_do_d = {2'd0, maddr_q};
        REG_MESHCOUNT: csr_do_d = {9'd0, cnt_y_q, 9'd0, cnt_x_q};
        REG_MESHSIZE:  csr_do_d = {5'd0, size_y_q, 5'd0, size_x_q};
        REG_FRAMECNT:  csr_do_d = frame_q;
        default:       csr_do_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      maddr_q     <= 30'd0;
      cnt_x_q     <= 7'd0;
      cnt_y_q     <= 7'd0;
      size_x_q    <= 11'd0;
      size_y_q    <= 11'd0;
      sh_addr_q   <= 30'd0;
      sh_cnt_x_q  <= 7'd0;
      sh_cnt_y_q  <= 7'd0;
      sh_size_x_q <= 11'd0;
      sh_size_y_q <= 11'd0;
      frame_q     <= 32'd0;
      start_q     <= 1'b0;
      zero_q      <= 1'b0;
      csr_do_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      irq_en_q    <= irq_en_d;
      irq_pend_q  <= irq_pend_d;
      maddr_q     <= maddr_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      size_x_q    <= size_x_d;
      size_y_q    <= size_y_d;
      sh_addr_q   <= sh_addr_d;
      sh_cnt_x_q  <= sh_cnt_x_d;
      sh_cnt_y_q  <= sh_cnt_y_d;
      sh_size_x_q <= sh_size_x_d;
      sh_size_y_q <= sh_size_y_d;
      frame_q     <= frame_d;
      start_q     <= start_d;
      zero_q      <= zero_d;
      csr_do_q    <= csr_do_d;
    end
  end

  assign csr_do       = csr_do_q;
  assign irq          = irq_pend_q && irq_en_q;
  assign meshaddr     = sh_addr_q;
  assign mesh_count_x = sh_cnt_x_q;
  assign mesh_count_y = sh_cnt_y_q;
  assign mesh_size_x  = sh_size_x_q;
  assign mesh_size_y  = sh_size_y_q;
  assign start        = start_q;
  assign dbg_state    = state_q;

endmodule
